// File: rtl/ram_req_ctrl_if.sv
// Request/response channel between an upstream master and the RAM request controller.
// The master issues read/write requests and consumes read responses under backpressure.
interface ram_req_ctrl_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/ram_req_ctrl.sv
// Request controller in front of a single-port synchronous RAM (1-cycle read latency).
// Turns valid/ready requests into RAM cycles, returns read data with backpressure, and can fill the RAM.
module ram_req_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init_start,
   input  logic [DATA_WIDTH-1:0] init_value,
   output logic                  init_busy,
   output logic                  init_done,
   ram_req_ctrl_if.slave         bus,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, INIT, RD_WAIT, RSP} state_t;

   state_t                state, state_nxt;
   logic                  ready_q;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_oob;
   logic [DATA_WIDTH-1:0] fill;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic idle_ok, start_fire, req_ready_i, wr_fire, rd_fire, in_range, last_fill;

   // ready_q keeps the controller quiet for the first cycle after reset release.
   assign idle_ok     = (state == IDLE) && ready_q;
   assign start_fire  = idle_ok && init_start;
   assign req_ready_i = idle_ok && !init_start;
   assign wr_fire     = bus.req_valid && req_ready_i && bus.req_we;
   assign rd_fire     = bus.req_valid && req_ready_i && !bus.req_we;
   assign in_range    = {1'b0, bus.req_addr} < DEPTH_W;
   assign last_fill   = (cnt == LAST_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start_fire)   state_nxt = INIT;
            else if (rd_fire) state_nxt = RD_WAIT;
         end
         INIT:    if (last_fill) state_nxt = IDLE;
         RD_WAIT: state_nxt = RSP;
         RSP:     if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ram_we   = 1'b0;
      ram_addr = bus.req_addr;
      ram_din  = bus.req_wdata;
      unique case (state)
         IDLE:    ram_we = wr_fire && in_range;
         INIT: begin
            ram_we   = 1'b1;
            ram_addr = cnt;
            ram_din  = fill;
         end
         RD_WAIT: ram_addr = rd_addr;
         default: ;
      endcase
   end

   assign bus.req_ready = req_ready_i;
   assign bus.rsp_valid = (state == RSP);
   assign bus.rsp_rdata = rdata_q;
   assign init_busy     = (state == INIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q   <= 1'b0;
         init_done <= 1'b0;
         cnt       <= '0;
         fill      <= '0;
         rd_addr   <= '0;
         rd_oob    <= 1'b0;
         rdata_q   <= '0;
      end else begin
         ready_q   <= 1'b1;
         init_done <= (state == INIT) && last_fill;
         if (start_fire) begin
            fill <= init_value;
            cnt  <= '0;
         end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
         end
         if (rd_fire) begin
            rd_addr <= bus.req_addr;
            rd_oob  <= !in_range;
         end
         // Out-of-range reads still take the normal path but return zero.
         if (state == RD_WAIT) rdata_q <= rd_oob ? '0 : ram_dout;
      end
   end

endmodule
